uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The module SHALL have parameter TIMING_BITS, default 24: width of the baud counter.
REQ-002 The module SHALL have parameter CLOCKS_PER_BAUD, default 10000: clocks per bit at 8N1 (10000 = 9600 baud @ 96 MHz); legal range is 4 to 2^TIMING_BITS-1.
REQ-003 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 o_wr  output  1  one-cycle strobe: o_data holds a valid received byte.
REQ-007 o_data  output  8  last received byte; held until the next valid byte.
REQ-008 o_frame_err  output  1  one-cycle strobe: stop bit sampled low.
REQ-009 o_break  output  1  level: line-break detected; held until the line returns high.

Function
REQ-010 i_uart_rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-011 States SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-012 IDLE: on rx_s low, load the counter with CLOCKS_PER_BAUD/2-1 (integer division) and go to START.
REQ-013 The counter SHALL decrement once per clock; a "sample" is the clock where the counter equals 0, and every sample SHALL reload the counter with CLOCKS_PER_BAUD-1.
REQ-014 START sample: rx_s high -> false start, return to IDLE with no output; rx_s low -> go to DATA with bit index 0.
REQ-015 DATA: each sample shifts rx_s into the shift register LSB-first and increments the index; after index 7 is sampled, go to STOP.
REQ-016 STOP sample, rx_s high: o_data <= shift register and o_wr=1 for exactly the next clock, then go to IDLE.
REQ-017 STOP sample, rx_s low: o_frame_err=1 for one clock, no o_wr, o_data unchanged, go to WAIT_IDLE.
REQ-018 If the stop bit is low and all 8 data bits are 0, o_break SHALL assert together with o_frame_err.
REQ-019 WAIT_IDLE SHALL ignore the line until rx_s is high, then clear o_break and go to IDLE; no start bit is accepted while in WAIT_IDLE.
REQ-020 A new start bit SHALL be accepted from the first clock after the STOP sample that returns to IDLE, so back-to-back frames are received without loss.
REQ-021 Byte latency SHALL be 2 synchronizer clocks + ~9.5 bit times from the start-bit falling edge to o_wr.
REQ-022 o_wr and o_frame_err SHALL never be asserted in the same clock.

Reset
REQ-023 While i_reset=1: state=IDLE, counter=0, index=0, shift register=0, synchronizer flops=1 (idle), o_wr=0, o_data=8'h00, o_frame_err=0, o_break=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame without any strobe.
REQ-025 After reset releases, reception SHALL start only on a fresh high-to-low edge.

Structure
REQ-026 A shared package/include SHALL hold the state encodings and the default CLOCKS_PER_BAUD/TIMING_BITS constants, shared with the transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module named sync_2ff (1-bit, reset value parameterized, here 1).
REQ-028 There SHALL be no other sub-modules; RTL is expected to be 120-250 lines.

Verification (CLOCKS_PER_BAUD=16, line driven by txuartlite with same setting unless noted)
REQ-029 Send 8'h0A -> exactly one o_wr pulse, o_data=8'h0A, o_frame_err=0.
REQ-030 Send 8'h55 and 8'hAA back-to-back (tx_stb held) -> two o_wr pulses, data 0x55 then 0xAA, spaced 160 clocks.
REQ-031 Glitch: line low for 4 clocks, then high -> no o_wr, FSM back in IDLE; then send 8'h3C -> o_data=8'h3C.
REQ-032 Hand-driven frame 8'hC3 with stop bit low -> one o_frame_err pulse, no o_wr, o_data keeps its previous value; line high -> next byte received normally.
REQ-033 Line held low for 40 bit times -> o_frame_err pulse and o_break=1 until the line goes high, then o_break=0; no o_wr.
REQ-034 Assert i_reset during data bit 4 of 8'hFF -> all outputs reset values, no strobe; next 8'h81 received correctly.

Source files
------------

// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: FSM state encodings, default timing constants
// and the receiver output payload. Also used by the matching transmitter.
package uart_byte_rx_pkg;

  localparam int unsigned UART_TIMING_BITS     = 24;
  localparam int unsigned UART_CLOCKS_PER_BAUD = 10000;  // 9600 baud @ 96 MHz

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_START     = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA      = 3'd2;
  localparam logic [ST_W-1:0] ST_STOP      = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_IDLE = 3'd4;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  // Registered receiver outputs, kept together so they update as one.
  typedef struct packed {
    logic              wr;
    logic [BYTE_W-1:0] data;
    logic              frame_err;
    logic              brk;
  } rx_out_t;

  // First countdown after the start edge lands in the middle of the start bit.
  function automatic int unsigned half_baud_reload(input int unsigned cpb);
    return (cpb / 2) - 1;
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Receiver-side bus: serial line in, byte/strobe/status out.
interface uart_byte_rx_if;

  logic       i_uart_rx;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_break;

  // master: the receiver itself
  modport master (
    input  i_uart_rx,
    output o_wr,
    output o_data,
    output o_frame_err,
    output o_break
  );

  // slave: whoever drives the line and consumes the bytes
  modport slave (
    output i_uart_rx,
    input  o_wr,
    input  o_data,
    input  o_frame_err,
    input  o_break
  );

endinterface

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value chosen
// by the instantiator so an idle-high line does not fake an edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver. Samples each bit at its centre using a down
// counter, reports good bytes, framing errors and line breaks.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int unsigned TIMING_BITS     = UART_TIMING_BITS,
  parameter int unsigned CLOCKS_PER_BAUD = UART_CLOCKS_PER_BAUD
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_byte_rx_if.master bus
);

  localparam logic [TIMING_BITS-1:0] HALF_RELOAD =
    TIMING_BITS'(half_baud_reload(CLOCKS_PER_BAUD));
  localparam logic [TIMING_BITS-1:0] BAUD_RELOAD =
    TIMING_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

  logic                   rx_s;
  logic [ST_W-1:0]        state_q, state_d;
  logic [TIMING_BITS-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [BYTE_W-1:0]      sh_q, sh_d;
  rx_out_t                out_q, out_d;
  logic                   sample_c;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (i_clk),
    .rst (i_reset),
    .d   (bus.i_uart_rx),
    .q   (rx_s)
  );

  assign sample_c = (cnt_q == '0);

  // State, timing and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
    end
  end

  // Next-state and next-output logic; strobes default low every clock.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    sh_d            = sh_q;
    out_d           = out_q;
    out_d.wr        = 1'b0;
    out_d.frame_err = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_RELOAD;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (sample_c) begin
          cnt_d = BAUD_RELOAD;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - TIMING_BITS'(1);
        end
      end

      ST_DATA: begin
        if (sample_c) begin
          cnt_d = BAUD_RELOAD;
          sh_d  = {rx_s, sh_q[BYTE_W-1:1]};
          idx_d = IDX_W'(idx_q + IDX_W'(1));
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q - TIMING_BITS'(1);
        end
      end

      ST_STOP: begin
        if (sample_c) begin
          cnt_d = BAUD_RELOAD;
          if (rx_s) begin
            out_d.wr   = 1'b1;
            out_d.data = sh_q;
            state_d    = ST_IDLE;
          end else begin
            // All-zero data with a low stop bit means the line is held low.
            out_d.frame_err = 1'b1;
            out_d.brk       = (sh_q == '0);
            state_d         = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - TIMING_BITS'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (rx_s) begin
          out_d.brk = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_wr        = out_q.wr;
  assign bus.o_data      = out_q.data;
  assign bus.o_frame_err = out_q.frame_err;
  assign bus.o_break     = out_q.brk;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 16 clocks per bit: a table of
// single frames, hand-written corner sequences and a randomized frame
// stream checked against a frame-level expectation model.
module tb_uart_byte_rx;

  localparam int unsigned CPB = 16;
  // 2 sync flops + 1 detect clock + half a bit to start centre + 9 bits to stop centre
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_byte_rx_if bus();

  uart_byte_rx #(
    .TIMING_BITS     (8),
    .CLOCKS_PER_BAUD (CPB)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    bit         is_wr;
    logic [7:0] data;
    logic       brk;
    int         at;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         exp_wr;
    logic [7:0] exp_data;
    logic       exp_brk;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   both_cnt = 0;
  ev_t  ev_q[$];
  ev_t  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the output values present alongside it.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (bus.o_wr && bus.o_frame_err) both_cnt++;
      if (bus.o_wr) begin
        e.is_wr = 1'b1; e.data = bus.o_data; e.brk = bus.o_break; e.at = cyc;
        ev_q.push_back(e);
      end
      if (bus.o_frame_err) begin
        e.is_wr = 1'b0; e.data = bus.o_data; e.brk = bus.o_break; e.at = cyc;
        ev_q.push_back(e);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bits(input logic lvl, input int n);
    bus.i_uart_rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int gap_bits, output int t0);
    t0 = cyc;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(d[i], CPB);
    drive_bits(stop, CPB);
    if (gap_bits > 0) drive_bits(1'b1, gap_bits * CPB);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wr"},   longint'(bus.o_wr),        0);
    chk({tag, "_data"}, longint'(bus.o_data),      0);
    chk({tag, "_ferr"}, longint'(bus.o_frame_err), 0);
    chk({tag, "_brk"},  longint'(bus.o_break),     0);
  endtask

  vec_t vecs[7];

  initial begin
    int t0, t1;
    logic [7:0] last_good;
    logic [7:0] d;
    logic       stop;
    int         gap;
    ev_t        e;

    vecs[0] = '{8'h0A, 1'b1, 1'b1, 8'h0A, 1'b0};
    vecs[1] = '{8'hC3, 1'b0, 1'b0, 8'h0A, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 8'h0A, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};

    rst = 1'b1;
    bus.i_uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    drive_bits(1'b1, 2 * CPB);

    // Single frames from the table
    for (int i = 0; i < 7; i++) begin
      ev_q.delete();
      send_frame(vecs[i].data, vecs[i].stop, 2, t0);
      chk($sformatf("vec%0d_events", i), ev_q.size(), 1);
      if (ev_q.size() > 0) begin
        chk($sformatf("vec%0d_is_wr", i),   longint'(ev_q[0].is_wr), longint'(vecs[i].exp_wr));
        chk($sformatf("vec%0d_data", i),    longint'(ev_q[0].data),  longint'(vecs[i].exp_data));
        chk($sformatf("vec%0d_brk", i),     longint'(ev_q[0].brk),   longint'(vecs[i].exp_brk));
        chk($sformatf("vec%0d_latency", i), ev_q[0].at - t0, LAT);
      end
      chk($sformatf("vec%0d_data_hold", i), longint'(bus.o_data), longint'(vecs[i].exp_data));
      chk($sformatf("vec%0d_brk_after", i), longint'(bus.o_break), 0);
    end

    // Back-to-back frames with no idle time between them
    ev_q.delete();
    send_frame(8'h55, 1'b1, 0, t0);
    send_frame(8'hAA, 1'b1, 3, t1);
    chk("b2b_events", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      chk("b2b_first",   longint'(ev_q[0].data), 8'h55);
      chk("b2b_second",  longint'(ev_q[1].data), 8'hAA);
      chk("b2b_spacing", ev_q[1].at - ev_q[0].at, 10 * CPB);
      chk("b2b_latency", ev_q[0].at - t0, LAT);
    end

    // Short low glitch is a false start
    ev_q.delete();
    drive_bits(1'b0, 4);
    drive_bits(1'b1, 2 * CPB);
    chk("glitch_events", ev_q.size(), 0);
    send_frame(8'h3C, 1'b1, 2, t0);
    chk("glitch_next_events", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk("glitch_next_data",    longint'(ev_q[0].data), 8'h3C);
      chk("glitch_next_latency", ev_q[0].at - t0, LAT);
    end

    // Line break: held low for 40 bit times
    ev_q.delete();
    drive_bits(1'b0, 40 * CPB);
    chk("break_level_low", longint'(bus.o_break), 1);
    chk("break_events", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      chk("break_is_ferr", longint'(ev_q[0].is_wr), 0);
      chk("break_with_ferr", longint'(ev_q[0].brk), 1);
    end
    drive_bits(1'b1, CPB);
    chk("break_cleared", longint'(bus.o_break), 0);
    chk("break_no_wr", ev_q.size(), 1);
    chk("break_data_hold", longint'(bus.o_data), 8'h3C);

    // Reset in the middle of data bit 4 of 0xFF
    ev_q.delete();
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bits(1'b1, CPB);
    drive_bits(1'b1, CPB / 2);
    rst = 1'b1;
    drive_bits(1'b1, 2);
    chk_idle_outputs("midreset");
    rst = 1'b0;
    drive_bits(1'b1, CPB / 2 - 2);
    drive_bits(1'b1, 4 * CPB);
    drive_bits(1'b1, 2 * CPB);
    chk("midreset_events", ev_q.size(), 0);
    send_frame(8'h81, 1'b1, 2, t0);
    chk("post_reset_events", ev_q.size(), 1);
    if (ev_q.size() > 0) chk("post_reset_data", longint'(ev_q[0].data), 8'h81);

    // Randomized frame stream against the frame-level model
    ev_q.delete();
    exp_q.delete();
    last_good = 8'h81;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      if (n % 8 == 5) begin
        d    = 8'h00;
        stop = 1'b0;
      end
      gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      e.at = 0;
      if (stop) begin
        last_good = d;
        e.is_wr = 1'b1; e.data = d; e.brk = 1'b0;
      end else begin
        e.is_wr = 1'b0; e.data = last_good; e.brk = (d == 8'h00);
      end
      exp_q.push_back(e);
      send_frame(d, stop, gap, t0);
    end
    drive_bits(1'b1, 2 * CPB);
    chk("rand_events", ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      chk($sformatf("rand%0d_is_wr", i), longint'(ev_q[i].is_wr), longint'(exp_q[i].is_wr));
      chk($sformatf("rand%0d_data", i),  longint'(ev_q[i].data),  longint'(exp_q[i].data));
      chk($sformatf("rand%0d_brk", i),   longint'(ev_q[i].brk),   longint'(exp_q[i].brk));
    end
    chk("rand_final_data", longint'(bus.o_data), longint'(last_good));

    chk("wr_ferr_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
